// File: rtl/fetch_sequencer.sv
// Front-end fetch sequencer: PC register, imem read, and a 2-entry
// {pc, instr} buffer toward decode with redirect and fault handling.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_enable,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  // 33 bits so a full 4 GiB memory size still compares correctly
  localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) << 2;

  logic [31:0] pc_q, pc_d;
  logic        fault_q, fault_d;
  logic [1:0]  count_q, count_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  entry_t      buf_q [2];

  logic   pop;
  logic   bad;
  logic   can_fetch;
  logic   push;
  logic   fault_set;
  entry_t ent;

  always_comb begin
    pop       = (count_q != 2'd0) & out_ready;
    bad       = ({1'b0, pc_q} >= MEM_BYTES)
              | (pc_q[1:0] != 2'b00);
    can_fetch = fetch_enable & ~fault_q & ~redirect_valid;
    push      = can_fetch & ~bad
              & ((count_q != 2'd2) | pop);
    fault_set = can_fetch & bad;
    ent       = '{pc: pc_q, instr: imem_instr};
  end

  always_comb begin
    pc_d    = pc_q;
    fault_d = fault_q;
    count_d = count_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      fault_d = 1'b0;
      count_d = 2'd0;
      wr_d    = 1'b0;
      rd_d    = 1'b0;
    end else begin
      if (push) begin
        pc_d = pc_q + 32'd4;
        wr_d = ~wr_q;
      end
      if (pop) begin
        rd_d = ~rd_q;
      end
      if (fault_set) begin
        fault_d = 1'b1;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
      count_q <= 2'd0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      fault_q <= fault_d;
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // Slot under the read pointer is never written while it is the
  // un-popped head, so head outputs stay stable under backpressure.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      buf_q[0] <= '0;
      buf_q[1] <= '0;
    end else if (push) begin
      buf_q[wr_q] <= ent;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = buf_q[rd_q].pc;
  assign out_instr = buf_q[rd_q].instr;
  assign fault     = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed bench for fetch_sequencer against a
// queue-based behavioural model of the fetch rules.
module tb_fetch_sequencer;

  localparam int unsigned MEM_WORDS = 128;
  localparam logic [31:0] RESET_PC  = 32'h0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_enable = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fault;

  fetch_sequencer #(
    .RESET_PC (RESET_PC),
    .MEM_WORDS(MEM_WORDS)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .fetch_enable  (fetch_enable),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .fault         (fault)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < MEM_WORDS * 4 && a[1:0] == 2'b00)
      return 32'hA000_0000 + (a >> 2);
    return 32'hBAD0_0000 ^ a;
  endfunction

  always_comb imem_instr = mem_word(imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pc;
  logic        m_fault;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h want %h at %0t",
               tag, got, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc    = RESET_PC;
    m_fault = 1'b0;
  endtask

  task automatic compare();
    chk("valid", 32'(out_valid), 32'(m_q.size() != 0));
    chk("fault", 32'(fault), 32'(m_fault));
    chk("addr", imem_addr, m_pc);
    if (m_q.size() != 0) begin
      chk("out_pc", out_pc, m_q[0].pc);
      chk("out_instr", out_instr, m_q[0].instr);
    end else begin
      chk("pc_known", 32'($isunknown(out_pc)), 32'd0);
    end
  endtask

  task automatic model_step(input logic fe, input logic rv,
                            input logic [31:0] rpc,
                            input logic ordy);
    bit pop;
    bit bad;
    int cnt0;
    cnt0 = m_q.size();
    pop  = (cnt0 != 0) && ordy;
    if (rv) begin
      m_q.delete();
      m_pc    = rpc;
      m_fault = 1'b0;
    end else begin
      bad = (m_pc >= MEM_WORDS * 4) || (m_pc % 4 != 0);
      if (pop) void'(m_q.pop_front());
      if (fe && !m_fault) begin
        if (bad) begin
          m_fault = 1'b1;
        end else if (cnt0 < 2 || pop) begin
          m_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic cycle(input logic fe, input logic rv,
                       input logic [31:0] rpc,
                       input logic ordy);
    @(negedge clock);
    fetch_enable   = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = ordy;
    #1;
    compare();
    model_step(fe, rv, rpc, ordy);
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    fetch_enable   = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    reset          = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
  endtask

  logic [31:0] tgt;

  initial begin
    model_reset();
    #3;
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    do_reset();

    // stream
    for (int i = 0; i < 22; i++) cycle(1, 0, 0, 1);

    // backpressure
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0);
    chk("bp_addr", imem_addr, 32'h8);
    chk("bp_pc", out_pc, 32'h0);
    chk("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1);

    // redirect with simultaneous pop, FIFO holding 4 and 8
    do_reset();
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 0);
    chk("rd_head", out_pc, 32'h4);
    cycle(1, 1, 32'h40, 1);
    chk("rd_valid", 32'(out_valid), 32'd0);
    chk("rd_addr", imem_addr, 32'h40);
    cycle(1, 0, 0, 1);
    chk("rd_tgt", out_pc, 32'h40);
    cycle(1, 0, 0, 1);

    // end of memory
    cycle(1, 1, 32'h1F8, 1);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1);
    chk("eom_fault", 32'(fault), 32'd1);
    chk("eom_addr", imem_addr, 32'h200);
    cycle(1, 0, 0, 1);
    cycle(1, 1, 32'h10, 1);
    chk("eom_clr", 32'(fault), 32'd0);
    chk("eom_resume", imem_addr, 32'h10);
    cycle(1, 0, 0, 1);
    chk("eom_pc", out_pc, 32'h10);

    // misaligned redirect
    cycle(1, 1, 32'h6, 1);
    cycle(1, 0, 0, 1);
    chk("mis_fault", 32'(fault), 32'd1);
    chk("mis_valid", 32'(out_valid), 32'd0);

    // async reset with two entries buffered
    cycle(1, 1, 32'h20, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    chk("ar_pre", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_fault", 32'(fault), 32'd0);
    chk("ar_addr", imem_addr, RESET_PC);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      tgt = {$urandom_range(0, 127), 2'b00};
      case ($urandom_range(0, 3))
        0: ;
        1: tgt = 32'h1F0 + {$urandom_range(0, 5), 2'b00};
        2: tgt = tgt | 32'($urandom_range(1, 3));
        default: tgt = $urandom;
      endcase
      cycle(($urandom_range(0, 9) < 8),
            ($urandom_range(0, 19) == 0),
            tgt,
            ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
